byte_link_checker: RTL and testbench
====================================

Name: byte_link_checker

Overview:
- Host-side bring-up block that sits at the far end of the test chip's 8-bit byte interface.
- Drives the chip's reset and byte input with a generated pattern, then samples the chip's byte output.
- Checks each returned byte against a model of the chip datapath: the output equals the input plus OFFSET, LATENCY cycles later.
- Reports pass/fail, a saturating error count and the first mismatch; used in FPGA bring-up and in the chip-level testbench.

Parameters:
- WIDTH, 8: byte-bus width.
- LATENCY, 5: clock cycles from a byte appearing on dut_in to its result being sampled on dut_out (≥1).
- OFFSET, 4: expected additive transform, computed mod 2^WIDTH.
- CNT_W, 16: width of the byte count, error count and index fields.
- RST_CYCLES, 4: number of cycles dut_reset is held high at test start (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run a test; ignored while busy.
- num_bytes  in  CNT_W  number of bytes to drive; sampled with start.
- seed  in  WIDTH  first pattern value; sampled with start.
- mode  in  1  pattern select: 0 = increment (seed+k), 1 = alternate (seed, ~seed, ...); sampled with start.
- dut_reset  out  1  reset to the chip.
- dut_in  out  WIDTH  registered byte driven to the chip.
- dut_out  in  WIDTH  byte returned by the chip.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a test completes.
- pass  out  1  result of the last completed test: 1 = no mismatches.
- err_count  out  CNT_W  number of mismatches, saturating at all-ones.
- first_err_idx  out  CNT_W  byte index k of the first mismatch.
- first_err_got  out  WIDTH  dut_out value at the first mismatch.

Behaviour:
- Reset values:
  - State is IDLE.
  - dut_reset, dut_in, busy, done, pass, err_count, first_err_idx, first_err_got and the expected-pipe valid bits are all 0.
- State machine (IDLE, DUT_RST, DRIVE, DRAIN, DONE):
  - IDLE: on start, latch num_bytes, seed and mode; clear err_count, first_err_* and pass; go to DUT_RST.
  - DUT_RST: dut_reset=1 and dut_in=0 for exactly RST_CYCLES cycles. Then go to DRIVE if num_bytes≠0, otherwise to DONE.
  - DRIVE: byte k (k=0..num_bytes-1) is on dut_in during the k-th DRIVE cycle, with dut_reset=0. After the last byte, go to DRAIN.
  - DRAIN: dut_in=0 for LATENCY cycles, then go to DONE.
  - DONE: done=1 for one cycle and pass = (err_count==0); return to IDLE. pass, err_count and first_err_* hold until the next accepted start.
- Pattern arithmetic:
  - Mode 0: value_k = seed + k, mod 2^WIDTH, so wrap-around is required.
  - Mode 1: value_k = seed for even k, ~seed for odd k.
- Checking:
  - A LATENCY-deep shift register carries {valid, expected=value_k+OFFSET mod 2^WIDTH, k}.
  - An entry is pushed for each DRIVE cycle; 0-valid entries are pushed in every other state.
  - dut_out is compared at each clock edge where the pipe output is valid. Byte k is therefore checked at the edge ending cycle (first DRIVE cycle + k + LATENCY).
  - The last compare happens at the edge ending the final DRAIN cycle, so the DONE result includes every byte.
  - A mismatch increments err_count, which saturates and never wraps.
  - On the first mismatch only, capture first_err_idx=k and first_err_got=dut_out.
  - dut_out is ignored whenever the pipe output is not valid, including DUT_RST and the first LATENCY DRIVE cycles.
- Timing: with start sampled at edge E, done is high during cycle E + RST_CYCLES + num_bytes + LATENCY + 1. For num_bytes=0 it is cycle E + RST_CYCLES + 1.
- Simultaneous events:
  - start while busy is dropped, not queued.
  - start in the DONE cycle is ignored.
  - start in the cycle after DONE is accepted.
- Reset mid-operation: any state returns to IDLE with all outputs at reset values. The pipe is flushed, and no done pulse is produced.

Test Plan:
1. Ideal model DUT (5-stage pipe, +4); start with seed=0x10, num_bytes=8, mode=0.
   - dut_reset high 4 cycles, then dut_in=0x10..0x17.
   - done at cycle E+18 with pass=1, err_count=0.
2. Wrap-around: seed=0xFE, num_bytes=4, mode=0.
   - dut_in=FE,FF,00,01; expected 02,03,04,05; pass=1.
3. Fault injection: the model flips bit0 of the result for byte 3 only; seed=0x10, num=8.
   - err_count=1, first_err_idx=3, first_err_got=0x16, pass=0.
   - With the fault on bytes 3 and 5: err_count=2, first_err_idx still 3.
4. Boundaries:
   - num_bytes=0: done at E+5, pass=1, no DRIVE cycles.
   - Second start pulse during DRIVE: ignored; dut_in sequence and result unchanged.
5. Mode 1, seed=0xA5, num=4, ideal DUT:
   - dut_in=A5,5A,A5,5A; pass=1.
   - Then a model with LATENCY 6: every byte mismatches, err_count=4, pass=0.
6. Reset asserted mid-DRIVE:
   - Next cycle all outputs are 0, busy=0, no done pulse.
   - A following start runs a clean test with pass=1.

Source files
------------

// File: rtl/byte_link_checker.sv
// byte_link_checker
//   Host-side bring-up checker for an 8-bit byte interface. On request it holds
//   the chip in reset, streams a generated byte pattern into it, then compares
//   every returned byte against the expected datapath result (input + OFFSET,
//   LATENCY cycles later). It reports pass/fail, a saturating error count and
//   details of the first mismatch.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   start          : one-cycle test request, ignored while busy
//   num_bytes      : number of bytes to drive (sampled with start)
//   seed           : first pattern value (sampled with start)
//   mode           : 0 = seed+k, 1 = seed/~seed alternating (sampled with start)
//   dut_reset      : reset driven to the chip
//   dut_in         : registered byte driven to the chip
//   dut_out        : byte returned by the chip
//   busy           : high whenever a test is in progress
//   done           : one-cycle completion pulse
//   pass           : last test result, 1 = no mismatches
//   err_count      : mismatch count, saturating
//   first_err_idx  : byte index of the first mismatch
//   first_err_got  : dut_out value seen at the first mismatch
module byte_link_checker #(
  parameter int WIDTH      = 8,
  parameter int LATENCY    = 5,
  parameter int OFFSET     = 4,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_bytes,
  input  logic [WIDTH-1:0] seed,
  input  logic             mode,
  output logic             dut_reset,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_got
);

  typedef enum logic [2:0] {IDLE, DUT_RST, DRIVE, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [WIDTH-1:0] seed_lat;
  logic             mode_lat;
  logic [CNT_W-1:0] byte_idx;
  logic [CNT_W-1:0] cyc_cnt;

  // Expected-result pipe: one stage per cycle of chip latency.
  logic [LATENCY-1:0] vld_p;
  logic [WIDTH-1:0]   exp_p [LATENCY];
  logic [CNT_W-1:0]   idx_p [LATENCY];

  logic             mismatch;
  logic [CNT_W-1:0] err_next;

  function automatic logic [WIDTH-1:0] pattern_at(input logic [WIDTH-1:0] s,
                                                  input logic m,
                                                  input logic [CNT_W-1:0] k);
    if (m) return k[0] ? ~s : s;
    return s + WIDTH'(k);
  endfunction

  function automatic logic [WIDTH-1:0] expect_of(input logic [WIDTH-1:0] v);
    return v + WIDTH'(OFFSET);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign mismatch = vld_p[LATENCY-1] && (dut_out != exp_p[LATENCY-1]);
  assign err_next = mismatch ? sat_inc(err_count) : err_count;

  // Test configuration, captured when a start is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      num_lat  <= num_bytes;
      seed_lat <= seed;
      mode_lat <= mode;
    end
  end

  // Pipe stage boundary: byte on dut_in enters stage 0, result leaves stage LATENCY-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (state == DRIVE);
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    exp_p[0] <= expect_of(dut_in);
    idx_p[0] <= byte_idx;
    for (int i = 1; i < LATENCY; i++) begin
      exp_p[i] <= exp_p[i-1];
      idx_p[i] <= idx_p[i-1];
    end
  end

  // Control FSM and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dut_reset     <= 1'b0;
      dut_in        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      byte_idx      <= '0;
      cyc_cnt       <= '0;
    end else begin
      done      <= 1'b0;
      err_count <= err_next;
      // First mismatch is recognised by the count still being zero.
      if (mismatch && err_count == '0) begin
        first_err_idx <= idx_p[LATENCY-1];
        first_err_got <= dut_out;
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            state         <= DUT_RST;
            busy          <= 1'b1;
            dut_reset     <= 1'b1;
            dut_in        <= '0;
            cyc_cnt       <= '0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
          end
        end
        DUT_RST: begin
          if (cyc_cnt == CNT_W'(RST_CYCLES - 1)) begin
            dut_reset <= 1'b0;
            cyc_cnt   <= '0;
            byte_idx  <= '0;
            if (num_lat != '0) begin
              state  <= DRIVE;
              dut_in <= pattern_at(seed_lat, mode_lat, '0);
            end else begin
              state <= DONE;
              done  <= 1'b1;
              pass  <= (err_next == '0);
            end
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (byte_idx == num_lat - CNT_W'(1)) begin
            state   <= DRAIN;
            dut_in  <= '0;
            cyc_cnt <= '0;
          end else begin
            byte_idx <= byte_idx + CNT_W'(1);
            dut_in   <= pattern_at(seed_lat, mode_lat, byte_idx + CNT_W'(1));
          end
        end
        DRAIN: begin
          // The edge leaving the last DRAIN cycle carries the final compare,
          // so pass is taken from the post-compare count.
          if (cyc_cnt == CNT_W'(LATENCY - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_link_checker.sv
module tb_byte_link_checker;

  logic        clk = 1'b0;
  logic        reset, start, mode;
  logic [15:0] num_bytes;
  logic [7:0]  seed;
  logic        dut_reset, busy, done, pass;
  logic [7:0]  dut_in, dut_out, first_err_got;
  logic [15:0] err_count, first_err_idx;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  byte_link_checker dut (
    .clk(clk), .reset(reset), .start(start), .num_bytes(num_bytes), .seed(seed),
    .mode(mode), .dut_reset(dut_reset), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_got(first_err_got)
  );

  // Chip model: configurable-latency pipe adding 4, with per-byte bit0 faults.
  logic [7:0]  ch_d [0:7];
  int          ch_i [0:7];
  int          ch_cnt = 0;
  int          chip_lat = 5;
  logic [31:0] fault_mask = '0;
  int          chip_idx;

  always @(posedge clk) begin
    ch_d[0] <= dut_in;
    ch_i[0] <= dut_reset ? -1 : ch_cnt;
    for (int i = 1; i < 8; i++) begin
      ch_d[i] <= ch_d[i-1];
      ch_i[i] <= ch_i[i-1];
    end
    ch_cnt <= dut_reset ? 0 : ch_cnt + 1;
  end

  always_comb begin
    chip_idx = ch_i[chip_lat-1];
    dut_out  = (ch_d[chip_lat-1] + 8'd4) ^
               {7'd0, (chip_idx >= 0 && chip_idx < 32) ? fault_mask[chip_idx] : 1'b0};
  end

  // Trace of one run, indexed by cycle number after the start edge.
  logic [7:0]  tr_in  [0:511];
  logic        tr_rst [0:511];
  int          done_n;
  logic        r_pass;
  logic [15:0] r_err, r_idx;
  logic [7:0]  r_got;

  function automatic logic [7:0] pat(input logic [7:0] s, input logic m, input int k);
    if (m) return (k % 2 == 1) ? ~s : s;
    return s + 8'(k);
  endfunction

  // Reference: the checker compares byte k against what the chip returns
  // LATENCY(=5) cycles after byte k was driven; a chip of latency cl returns
  // the byte driven at k+5-cl (0 before the first byte).
  task automatic model_run(input logic [7:0] s, input logic m, input int num,
                           input int cl, input logic [31:0] fm,
                           output int e_err, output int e_idx,
                           output logic [7:0] e_got, output int e_done);
    int j;
    logic [7:0] v, got, exp;
    e_err = 0; e_idx = 0; e_got = 8'h00;
    for (int k = 0; k < num; k++) begin
      exp = pat(s, m, k) + 8'd4;
      j   = k + 5 - cl;
      v   = (j >= 0) ? pat(s, m, j) : 8'h00;
      got = (v + 8'd4) ^ {7'd0, (j >= 0 && j < 32) ? fm[j] : 1'b0};
      if (got != exp) begin
        if (e_err == 0) begin e_idx = k; e_got = got; end
        e_err++;
      end
    end
    e_done = (num == 0) ? 5 : 4 + num + 5 + 1;
  endtask

  task automatic do_run(input logic [7:0] s, input logic m, input logic [15:0] num,
                        input int restart_at);
    int n;
    @(negedge clk);
    start = 1'b1; seed = s; mode = m; num_bytes = num;
    n = 0; done_n = -1;
    while (done_n < 0 && n < 500) begin
      @(negedge clk);
      n++;
      start = (n == restart_at);
      tr_in[n] = dut_in; tr_rst[n] = dut_reset;
      if (done) begin
        done_n = n; r_pass = pass; r_err = err_count;
        r_idx = first_err_idx; r_got = first_err_got;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; seed = '0; mode = 1'b0; num_bytes = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dut_reset, dut_in, busy, done, pass, err_count, first_err_idx, first_err_got} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got rst=%b in=%h busy=%b done=%b pass=%b err=%0d idx=%0d got=%h, want all 0",
               dut_reset, dut_in, busy, done, pass, err_count, first_err_idx, first_err_got);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    chip_lat = 5; fault_mask = '0;
    do_run(8'h10, 1'b0, 16'd8, -1);
    for (int n = 1; n <= 4; n++) begin
      vectors++;
      if (tr_rst[n] !== 1'b1 || tr_in[n] !== 8'h00) begin
        miscompares++;
        $display("FAIL basic_dut_rst cycle %0d: got rst=%b in=%h, want rst=1 in=00", n, tr_rst[n], tr_in[n]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if ({tr_rst[5+k], tr_in[5+k]} !== {1'b0, 8'h10 + 8'(k)}) begin
        miscompares++;
        $display("FAIL basic_byte %0d: got rst=%b in=%h, want rst=0 in=%h", k, tr_rst[5+k], tr_in[5+k], 8'h10 + 8'(k));
      end
    end
    vectors++;
    if (done_n !== 18 || r_pass !== 1'b1 || r_err !== 16'd0) begin
      miscompares++;
      $display("FAIL basic_result: got done@%0d pass=%b err=%0d, want done@18 pass=1 err=0", done_n, r_pass, r_err);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (pass !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold: got pass=%b busy=%b done=%b, want 1 0 0", pass, busy, done);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] want [0:3];
    want = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_run(8'hFE, 1'b0, 16'd4, -1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (tr_in[5+k] !== want[k]) begin
        miscompares++;
        $display("FAIL wrap_byte %0d: got %h, want %h", k, tr_in[5+k], want[k]);
      end
    end
    vectors++;
    if (done_n !== 14 || r_pass !== 1'b1 || r_err !== 16'd0) begin
      miscompares++;
      $display("FAIL wrap_result: got done@%0d pass=%b err=%0d, want done@14 pass=1 err=0", done_n, r_pass, r_err);
    end
  endtask

  task automatic test_fault;
    fault_mask = 32'h0000_0008;
    do_run(8'h10, 1'b0, 16'd8, -1);
    vectors++;
    if (r_err !== 16'd1 || r_idx !== 16'd3 || r_got !== 8'h16 || r_pass !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_single: got err=%0d idx=%0d got=%h pass=%b, want 1 3 16 0", r_err, r_idx, r_got, r_pass);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (err_count !== 16'd1 || first_err_idx !== 16'd3 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_hold: got err=%0d idx=%0d pass=%b, want 1 3 0", err_count, first_err_idx, pass);
    end
    fault_mask = 32'h0000_0028;
    do_run(8'h10, 1'b0, 16'd8, -1);
    vectors++;
    if (r_err !== 16'd2 || r_idx !== 16'd3 || r_got !== 8'h16 || r_pass !== 1'b0) begin
      miscompares++;
      $display("FAIL fault_double: got err=%0d idx=%0d got=%h pass=%b, want 2 3 16 0", r_err, r_idx, r_got, r_pass);
    end
    fault_mask = '0;
  endtask

  task automatic test_zero_len;
    do_run(8'h33, 1'b0, 16'd0, -1);
    vectors++;
    if (done_n !== 5 || r_pass !== 1'b1 || r_err !== 16'd0) begin
      miscompares++;
      $display("FAIL zero_len: got done@%0d pass=%b err=%0d, want done@5 pass=1 err=0", done_n, r_pass, r_err);
    end
    vectors++;
    if (tr_rst[4] !== 1'b1 || tr_rst[5] !== 1'b0 || tr_in[5] !== 8'h00) begin
      miscompares++;
      $display("FAIL zero_len_drive: got rst4=%b rst5=%b in5=%h, want 1 0 00", tr_rst[4], tr_rst[5], tr_in[5]);
    end
  endtask

  task automatic test_back_to_back;
    // Second start in the middle of DRIVE must not disturb the run.
    do_run(8'h10, 1'b0, 16'd8, 7);
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (tr_in[5+k] !== 8'h10 + 8'(k)) begin
        miscompares++;
        $display("FAIL restart_byte %0d: got %h, want %h", k, tr_in[5+k], 8'h10 + 8'(k));
      end
    end
    vectors++;
    if (done_n !== 18 || r_pass !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_result: got done@%0d pass=%b, want done@18 pass=1", done_n, r_pass);
    end
    // Start raised during the DONE cycle is dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0 || dut_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_done: got busy=%b rst=%b, want 0 0", busy, dut_reset);
    end
    // Start in the cycle right after DONE is accepted.
    do_run(8'h20, 1'b0, 16'd3, -1);
    do_run(8'h40, 1'b0, 16'd3, -1);
    vectors++;
    if (done_n !== 13 || r_pass !== 1'b1 || tr_in[5] !== 8'h40) begin
      miscompares++;
      $display("FAIL start_after_done: got done@%0d pass=%b in=%h, want done@13 pass=1 in=40", done_n, r_pass, tr_in[5]);
    end
  endtask

  task automatic test_mode1;
    logic [7:0] want [0:3];
    want = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};
    chip_lat = 5;
    do_run(8'hA5, 1'b1, 16'd4, -1);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (tr_in[5+k] !== want[k]) begin
        miscompares++;
        $display("FAIL alt_byte %0d: got %h, want %h", k, tr_in[5+k], want[k]);
      end
    end
    vectors++;
    if (r_pass !== 1'b1 || r_err !== 16'd0) begin
      miscompares++;
      $display("FAIL alt_result: got pass=%b err=%0d, want pass=1 err=0", r_pass, r_err);
    end
    chip_lat = 6;
    do_run(8'hA5, 1'b1, 16'd4, -1);
    vectors++;
    if (r_err !== 16'd4 || r_pass !== 1'b0 || r_idx !== 16'd0 || r_got !== 8'h04) begin
      miscompares++;
      $display("FAIL alt_lat6: got err=%0d pass=%b idx=%0d got=%h, want 4 0 0 04", r_err, r_pass, r_idx, r_got);
    end
    chip_lat = 5;
  endtask

  task automatic test_reset_mid;
    int seen;
    @(negedge clk);
    start = 1'b1; seed = 8'h10; mode = 1'b0; num_bytes = 16'd8;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({dut_reset, dut_in, busy, done, pass, err_count, first_err_idx, first_err_got} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got rst=%b in=%h busy=%b done=%b pass=%b err=%0d, want all 0",
               dut_reset, dut_in, busy, done, pass, err_count);
    end
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d cycles with done/busy, want 0", seen);
    end
    do_run(8'h10, 1'b0, 16'd8, -1);
    vectors++;
    if (done_n !== 18 || r_pass !== 1'b1 || r_err !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_mid_rerun: got done@%0d pass=%b err=%0d, want done@18 pass=1 err=0", done_n, r_pass, r_err);
    end
  endtask

  task automatic test_random;
    logic [7:0]  s;
    logic        m;
    int          num, e_err, e_idx, e_done;
    logic [7:0]  e_got;
    for (int it = 0; it < 10; it++) begin
      s   = 8'($urandom);
      m   = 1'($urandom);
      num = $urandom_range(0, 20);
      chip_lat   = (it % 4 == 3) ? 6 : 5;
      fault_mask = ($urandom_range(0, 1) == 1) ? ($urandom & $urandom) : 32'h0;
      model_run(s, m, num, chip_lat, fault_mask, e_err, e_idx, e_got, e_done);
      do_run(s, m, 16'(num), -1);
      for (int k = 0; k < num; k++) begin
        vectors++;
        if (tr_in[5+k] !== pat(s, m, k) || tr_rst[5+k] !== 1'b0) begin
          miscompares++;
          $display("FAIL rand%0d_byte %0d: got rst=%b in=%h, want rst=0 in=%h", it, k, tr_rst[5+k], tr_in[5+k], pat(s, m, k));
        end
      end
      vectors++;
      if (done_n !== e_done || r_pass !== (e_err == 0) || r_err !== 16'(e_err) ||
          r_idx !== 16'(e_idx) || r_got !== e_got) begin
        miscompares++;
        $display("FAIL rand%0d_result: got done@%0d pass=%b err=%0d idx=%0d got=%h, want done@%0d pass=%b err=%0d idx=%0d got=%h",
                 it, done_n, r_pass, r_err, r_idx, r_got, e_done, (e_err == 0), e_err, e_idx, e_got);
      end
    end
    chip_lat = 5; fault_mask = '0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_fault;
    test_zero_len;
    test_back_to_back;
    test_mode1;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
